rtc_bus_scheduler: RTL and testbench

Single owner of the multiplexed 8-bit RTC address/data bus (ad/cs/wr/rd strobes, active-low). It arbitrates round-robin between four clients: date-set, time-set, alarm-set and periodic readback. It then runs one complete bus cycle per grant: an address phase, a gap, and a write-data or read-data phase. Clients never touch the bus pins; this block sits between the client FSMs and the top-level pad drivers.

---
 rtl/rtc_bus_pkg.sv | 30 +++
 rtl/rtc_bus_scheduler_rr_arbiter4.sv | 26 ++
 rtl/rtc_bus_scheduler.sv | 136 +++++++++++++
 tb/tb_rtc_bus_scheduler.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared state encoding and constants for the RTC bus scheduler
package rtc_bus_pkg;

  // Bus-cycle states: address phase, gap, data phase, recovery
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_A_AD   = 4'd1;
  localparam logic [3:0] S_A_CS   = 4'd2;
  localparam logic [3:0] S_A_WR   = 4'd3;
  localparam logic [3:0] S_A_DRV  = 4'd4;
  localparam logic [3:0] S_A_WRH  = 4'd5;
  localparam logic [3:0] S_A_CSH  = 4'd6;
  localparam logic [3:0] S_A_ADH  = 4'd7;
  localparam logic [3:0] S_GAP    = 4'd8;
  localparam logic [3:0] S_D_CS   = 4'd9;
  localparam logic [3:0] S_D_STB  = 4'd10;
  localparam logic [3:0] S_D_DRV  = 4'd11;
  localparam logic [3:0] S_D_STBH = 4'd12;
  localparam logic [3:0] S_D_CSH  = 4'd13;
  localparam logic [3:0] S_RECOV  = 4'd14;

  // Value on ADout whenever the bus is not being driven
  localparam logic [7:0] BUS_IDLE = 8'hFF;

  // Client slots on req/rnw/addr_in/wdata_in
  localparam logic [1:0] DATE  = 2'd0;
  localparam logic [1:0] TIME  = 2'd1;
  localparam logic [1:0] ALARM = 2'd2;
  localparam logic [1:0] READ  = 2'd3;

endpackage

// File: rtl/rtc_bus_scheduler_rr_arbiter4.sv
// rtl/rtc_bus_scheduler_rr_arbiter4.sv - four-way round-robin arbiter starting at pointer
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       en,
  output logic [3:0] winner,
  output logic [1:0] next_ptr
);

  logic [1:0] idx;

  // Scan from the farthest offset down so the first requester at or after ptr wins
  always_comb begin
    winner   = 4'b0000;
    next_ptr = ptr;
    idx      = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (en && req[idx]) begin
        winner   = 4'b0001 << idx;
        next_ptr = idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/rtc_bus_scheduler.sv
// rtl/rtc_bus_scheduler.sv - arbitrates four clients and runs one RTC bus cycle per grant
module rtc_bus_scheduler
  import rtc_bus_pkg::*;
#(
  parameter int T_PULSE = 5,
  parameter int T_GAP   = 8,
  parameter int T_RECOV = 8,
  parameter int CNT_W   = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  rnw,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic [3:0]  grant,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [7:0]  ADout,
  output logic        ad_oe,
  input  logic [7:0]  ADin,
  output logic        ad,
  output logic        cs,
  output logic        wr,
  output logic        rd
);

  logic [3:0]       state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [1:0]       ptr, arb_next, win_idx;
  logic [3:0]       win;
  logic             capture;
  logic [7:0]       addr_q, wdata_q;
  logic             rnw_q;
  logic             ad_n, cs_n, wr_n, rd_n, oe_n;
  logic [7:0]       ad_out_n;

  rr_arbiter4 u_arb (
    .req      (req),
    .ptr      (ptr),
    .en       (state == S_IDLE),
    .winner   (win),
    .next_ptr (arb_next)
  );

  assign capture = |win;
  assign win_idx = arb_next - 2'd1;

  // Sequence through the bus cycle; multi-cycle states load their length on entry
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      S_IDLE:   if (capture) next_state = S_A_AD;
      S_A_AD:   next_state = S_A_CS;
      S_A_CS:   next_state = S_A_WR;
      S_A_WR:   begin next_state = S_A_DRV; next_cnt = CNT_W'(T_PULSE - 1); end
      S_A_DRV:  if (cnt == '0) next_state = S_A_WRH; else next_cnt = cnt - 1'b1;
      S_A_WRH:  next_state = S_A_CSH;
      S_A_CSH:  next_state = S_A_ADH;
      S_A_ADH:  begin next_state = S_GAP; next_cnt = CNT_W'(T_GAP - 1); end
      S_GAP:    if (cnt == '0) next_state = S_D_CS; else next_cnt = cnt - 1'b1;
      S_D_CS:   next_state = S_D_STB;
      S_D_STB:  begin next_state = S_D_DRV; next_cnt = CNT_W'(T_PULSE - 1); end
      S_D_DRV:  if (cnt == '0) next_state = S_D_STBH; else next_cnt = cnt - 1'b1;
      S_D_STBH: next_state = S_D_CSH;
      S_D_CSH:  begin next_state = S_RECOV; next_cnt = CNT_W'(T_RECOV - 1); end
      S_RECOV:  if (cnt == '0) next_state = S_IDLE; else next_cnt = cnt - 1'b1;
      default:  next_state = S_IDLE;
    endcase
  end

  // Pin values for the state being entered; the address is held through the wr/cs release
  always_comb begin
    ad_n     = !(next_state inside {S_A_AD, S_A_CS, S_A_WR, S_A_DRV, S_A_WRH, S_A_CSH});
    cs_n     = !(next_state inside {S_A_CS, S_A_WR, S_A_DRV, S_A_WRH,
                                    S_D_CS, S_D_STB, S_D_DRV, S_D_STBH});
    wr_n     = !((next_state inside {S_A_WR, S_A_DRV}) ||
                 ((next_state inside {S_D_STB, S_D_DRV}) && !rnw_q));
    rd_n     = !((next_state inside {S_D_STB, S_D_DRV}) && rnw_q);
    oe_n     = 1'b0;
    ad_out_n = BUS_IDLE;
    if (next_state inside {S_A_DRV, S_A_WRH, S_A_CSH}) begin
      oe_n     = 1'b1;
      ad_out_n = addr_q;
    end else if (next_state == S_D_DRV && !rnw_q) begin
      oe_n     = 1'b1;
      ad_out_n = wdata_q;
    end
  end

  // State, registered pins, capture of the winning client and read-data sampling
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ptr     <= DATE;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rnw_q   <= 1'b0;
      grant   <= 4'b0000;
      done    <= 1'b0;
      busy    <= 1'b0;
      rdata   <= 8'h00;
      ADout   <= BUS_IDLE;
      ad_oe   <= 1'b0;
      ad      <= 1'b1;
      cs      <= 1'b1;
      wr      <= 1'b1;
      rd      <= 1'b1;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      ad    <= ad_n;
      cs    <= cs_n;
      wr    <= wr_n;
      rd    <= rd_n;
      ad_oe <= oe_n;
      ADout <= ad_out_n;
      busy  <= (next_state != S_IDLE);
      done  <= (state == S_D_CSH);
      if (capture) begin
        grant   <= win;
        ptr     <= arb_next;
        addr_q  <= addr_in[{win_idx, 3'b000} +: 8];
        wdata_q <= wdata_in[{win_idx, 3'b000} +: 8];
        rnw_q   <= rnw[win_idx];
      end else if (done) begin
        grant <= 4'b0000;
      end
      if (state == S_D_DRV && cnt == '0 && rnw_q) rdata <= ADin;
    end
  end

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// tb/tb_rtc_bus_scheduler.sv - directed self-checking bench for rtc_bus_scheduler
module tb_rtc_bus_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req, rnw, grant;
  logic [31:0] addr_in, wdata_in;
  logic        done, busy, ad_oe, ad, cs, wr, rd;
  logic [7:0]  rdata, ADout, ADin;

  logic [3:0]  req_s, rnw_s, grant_s;
  logic [31:0] addr_in_s, wdata_in_s;
  logic        done_s, busy_s, ad_oe_s, ad_s, cs_s, wr_s, rd_s;
  logic [7:0]  rdata_s, ADout_s;

  int ntests = 0;
  int nfail  = 0;
  int ndone  = 0;
  int c      = 0;

  always #5 clock = ~clock;

  rtc_bus_scheduler dut (
    .clock(clock), .reset(reset), .req(req), .rnw(rnw), .addr_in(addr_in),
    .wdata_in(wdata_in), .grant(grant), .done(done), .rdata(rdata), .busy(busy),
    .ADout(ADout), .ad_oe(ad_oe), .ADin(ADin), .ad(ad), .cs(cs), .wr(wr), .rd(rd)
  );

  rtc_bus_scheduler #(.T_PULSE(1), .T_GAP(1), .T_RECOV(1), .CNT_W(6)) dut_s (
    .clock(clock), .reset(reset), .req(req_s), .rnw(rnw_s), .addr_in(addr_in_s),
    .wdata_in(wdata_in_s), .grant(grant_s), .done(done_s), .rdata(rdata_s), .busy(busy_s),
    .ADout(ADout_s), .ad_oe(ad_oe_s), .ADin(8'h00), .ad(ad_s), .cs(cs_s), .wr(wr_s), .rd(rd_s)
  );

  always @(negedge clock) if (done === 1'b1) ndone++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_to(input int k);
    while (c < k) begin
      @(posedge clock);
      @(negedge clock);
      c++;
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; rnw = '0; addr_in = '0; wdata_in = '0; ADin = 8'h00;
    req_s = '0; rnw_s = '0; addr_in_s = '0; wdata_in_s = '0;
    repeat (2) @(negedge clock);
    chk("rst_strobes", {ad, cs, wr, rd}, 4'hF);
    chk("rst_bus", {ADout, 3'b000, ad_oe}, {8'hFF, 4'h0});
    chk("rst_ctl", {grant, 2'b00, done, busy}, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    reset = 1'b0;

    // single write from client 0
    c = 0; req = 4'b0001; addr_in[7:0] = 8'h24; wdata_in[7:0] = 8'h15;
    run_to(1);  chk("w_c1", {ad, cs, wr, rd, busy, grant}, {5'b01111, 4'b0001});
    run_to(2);  chk("w_c2", {ad, cs, wr}, 3'b001); req = 4'b0000;
    run_to(3);  chk("w_c3", {ad, cs, wr, rd}, 4'b0001);
    run_to(4);  chk("w_c4", {ad_oe, ADout}, {1'b1, 8'h24});
    run_to(8);  chk("w_c8", {ad_oe, ADout}, {1'b1, 8'h24});
    run_to(11); chk("w_c11", {ad, cs, wr, ad_oe, ADout}, {4'b1110, 8'hFF});
    run_to(20); chk("w_c20", {cs, wr}, 2'b01);
    run_to(21); chk("w_c21", {cs, wr, rd}, 3'b001);
    run_to(22); chk("w_c22", {rd, ad_oe, ADout}, {2'b11, 8'h15});
    run_to(26); chk("w_c26", {wr, ad_oe, ADout}, {2'b01, 8'h15});
    run_to(27); chk("w_c27", {cs, wr, ad_oe, ADout}, {3'b010, 8'hFF});
    run_to(28); chk("w_c28", {cs, done}, 2'b10);
    run_to(29); chk("w_c29", {done, grant}, {1'b1, 4'b0001});
    run_to(30); chk("w_c30", {done, busy, grant}, {2'b01, 4'b0000});
    run_to(36); chk("w_c36", busy, 1'b1);
    run_to(37); chk("w_c37", busy, 1'b0);

    // single read from client 3
    c = 0; req = 4'b1000; rnw = 4'b1000; addr_in[31:24] = 8'h0A; ADin = 8'h11;
    run_to(1);  chk("r_c1", grant, 4'b1000);
    run_to(4);  chk("r_c4", ADout, 8'h0A);
    run_to(21); chk("r_c21", {wr, rd}, 2'b10);
    run_to(22); chk("r_c22", {wr, rd, ad_oe, ADout}, {3'b100, 8'hFF});
    run_to(26); chk("r_c26", {wr, rd, ad_oe}, 3'b100); ADin = 8'h5C;
    run_to(27); chk("r_c27", {rd, rdata}, {1'b1, 8'h5C}); ADin = 8'h00;
    run_to(29); chk("r_c29", {done, rdata}, {1'b1, 8'h5C});
    run_to(30); req = 4'b0000; rnw = 4'b0000;
    run_to(37); chk("r_c37", busy, 1'b0);

    // round robin with all clients held
    c = 0; req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      run_to(37 * n + 1);  chk($sformatf("rr_grant%0d", n), grant, 4'b0001 << (n % 4));
      run_to(37 * n + 28); chk($sformatf("rr_pre%0d", n), done, 1'b0);
      run_to(37 * n + 29); chk($sformatf("rr_done%0d", n), done, 1'b1);
    end
    run_to(150); req = 4'b0000;
    run_to(185); chk("rr_idle", busy, 1'b0);

    // pointer fairness: move pointer to 2 via client 1, then 0 and 1 compete
    c = 0; req = 4'b0010;
    run_to(1);  chk("pf_setup", grant, 4'b0010);
    run_to(30); req = 4'b0000;
    run_to(37);
    c = 0; req = 4'b0011;
    run_to(1);  chk("pf_first", grant, 4'b0001);
    run_to(38); chk("pf_second", grant, 4'b0010);
    run_to(40); req = 4'b0000;
    run_to(74);

    // async reset mid-write
    c = 0; req = 4'b0001;
    run_to(23); chk("ar_pre", {ad_oe, ADout}, {1'b1, 8'h15});
    reset = 1'b1;
    #1;
    chk("ar_pins", {ad, cs, wr, rd, ad_oe, ADout}, {5'b11110, 8'hFF});
    chk("ar_ctl", {grant, done, busy}, 6'b000000);
    @(posedge clock); @(negedge clock);
    chk("ar_nodone", done, 1'b0);
    reset = 1'b0;
    c = 0; req = 4'b0110;
    run_to(1);  chk("ar_ptr0", grant, 4'b0010);
    run_to(2);  req = 4'b0000;
    run_to(37); chk("ar_idle", busy, 1'b0);
    chk("done_count", ndone, 11);

    // short-timing instance
    c = 0; req_s = 4'b0100; addr_in_s[23:16] = 8'h3C; wdata_in_s[23:16] = 8'hC3;
    run_to(1);  chk("s_c1", {ad_s, cs_s, wr_s, grant_s}, {3'b011, 4'b0100});
    run_to(2);  req_s = 4'b0000;
    run_to(3);  chk("s_c3", {ad_s, cs_s, wr_s}, 3'b000);
    run_to(4);  chk("s_c4", {ad_oe_s, ADout_s}, {1'b1, 8'h3C});
    run_to(7);  chk("s_c7", {ad_s, ad_oe_s, ADout_s}, {2'b10, 8'hFF});
    run_to(10); chk("s_c10", {cs_s, wr_s, rd_s}, 3'b001);
    run_to(11); chk("s_c11", {ad_oe_s, ADout_s}, {1'b1, 8'hC3});
    run_to(13); chk("s_c13", {cs_s, done_s}, 2'b10);
    run_to(14); chk("s_c14", {done_s, busy_s}, 2'b11);
    run_to(15); chk("s_c15", {done_s, busy_s, grant_s}, 6'b000000);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
